imem_uart_loader: RTL and testbench

- Writer side of the instruction-memory interface. Today the IFU instruction memory `im` is only ever filled by simulation preload.
- This block receives a program image over a UART line (8N1) and writes 32-bit words into the instruction memory.
- It holds the CPU core stalled while loading, then releases it.
- Sits in the CPU top level, between the board RX pin and the IFU memory write port.

---
 rtl/imem_uart_loader_pkg.sv | 26 ++
 rtl/imem_uart_loader_if.sv | 11 +
 rtl/imem_uart_loader_uart_rx_byte.sv | 114 +++++++++++
 rtl/imem_uart_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory loader.
package imem_uart_loader_pkg;

  // Header byte that opens every program image.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Image-parsing FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  // UART receiver bit-level states.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port: loader drives, IFU memory receives.
interface imem_uart_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (output im_we, output im_addr, output im_wdata);
  modport slave  (input  im_we, input  im_addr, input  im_wdata);
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, start confirm, centre sampling, stop check.
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic          s1, s2, prev;
  rx_state_t     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    sh, sh_n;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rxd;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= RX_IDLE;
      cnt   <= '0;
      bit_q <= '0;
      sh    <= '0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      bit_q <= bit_n;
      sh    <= sh_n;
    end
  end

  // Bit timing and frame decode; byte_valid/frame_err are single-cycle strobes.
  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    bit_n      = bit_q;
    sh_n       = sh;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (st)
      RX_IDLE: begin
        if (prev && !s2) begin
          st_n  = RX_START;
          cnt_n = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          if (!s2) begin
            st_n  = RX_DATA;
            bit_n = '0;
          end else begin
            st_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {s2, sh[7:1]};
          if (bit_q == 3'd7) st_n = RX_STOP;
          else               bit_n = bit_q + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (s2) begin
            byte_valid = 1'b1;
            st_n       = RX_IDLE;
          end else begin
            frame_err = 1'b1;
            st_n      = RX_WAIT;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_WAIT: begin
        if (s2) st_n = RX_IDLE;
      end
      default: st_n = RX_IDLE;
    endcase
  end

  assign data = sh;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a UART-delivered program image into instruction memory while holding the CPU.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 434,
  parameter int unsigned ADDR_W        = 10,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  imem_uart_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  ld_state_t         st, st_n;
  logic [7:0]        len_l_q, len_l_n;
  logic [15:0]       wleft_q, wleft_n;
  logic [1:0]        bcnt_q, bcnt_n;
  logic [31:0]       asm_q, asm_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] wa_q, wa_n;
  logic [31:0]       wd_q, wd_n;
  logic              hold_q, hold_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic [15:0]       n_w;

  assign n_w = {rx_data, len_l_q};

  // Loader state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      len_l_q <= '0;
      wleft_q <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      hold_q  <= HOLD_AT_RESET;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st      <= st_n;
      len_l_q <= len_l_n;
      wleft_q <= wleft_n;
      bcnt_q  <= bcnt_n;
      asm_q   <= asm_n;
      addr_q  <= addr_n;
      we_q    <= we_n;
      wa_q    <= wa_n;
      wd_q    <= wd_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Image parser: header, 16-bit word count, then little-endian words.
  // The write strobe is registered here, so im_we lands one cycle after the 4th byte.
  always_comb begin
    st_n    = st;
    len_l_n = len_l_q;
    wleft_n = wleft_q;
    bcnt_n  = bcnt_q;
    asm_n   = asm_q;
    addr_n  = addr_q;
    we_n    = 1'b0;
    wa_n    = wa_q;
    wd_n    = wd_q;
    hold_n  = hold_q;
    done_n  = done_q;
    err_n   = err_q;
    unique case (st)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          st_n   = ST_LEN0;
          hold_n = 1'b1;
          done_n = 1'b0;
          err_n  = 1'b0;
          addr_n = '0;
        end
      end
      ST_LEN0: begin
        if (rx_ferr) begin
          st_n  = ST_ERR;
          err_n = 1'b1;
        end else if (rx_valid) begin
          len_l_n = rx_data;
          st_n    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_ferr) begin
          st_n  = ST_ERR;
          err_n = 1'b1;
        end else if (rx_valid) begin
          if (n_w == 16'd0) begin
            st_n   = ST_DONE;
            hold_n = 1'b0;
            done_n = 1'b1;
          end else if ({16'd0, n_w} > DEPTH) begin
            st_n  = ST_ERR;
            err_n = 1'b1;
          end else begin
            st_n    = ST_DATA;
            bcnt_n  = '0;
            wleft_n = n_w;
          end
        end
      end
      ST_DATA: begin
        if (rx_ferr) begin
          st_n  = ST_ERR;
          err_n = 1'b1;
        end else if (rx_valid) begin
          asm_n  = {rx_data, asm_q[31:8]};
          bcnt_n = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_n    = 1'b1;
            wd_n    = {rx_data, asm_q[31:8]};
            wa_n    = addr_q;
            addr_n  = addr_q + 1'b1;
            wleft_n = wleft_q - 16'd1;
            if (wleft_q == 16'd1) begin
              st_n   = ST_DONE;
              hold_n = 1'b0;
              done_n = 1'b1;
            end
          end
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end

  assign imem.im_we    = we_q;
  assign imem.im_addr  = wa_q;
  assign imem.im_wdata = wd_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader at CLK_DIV=8, ADDR_W=4.
module tb_imem_uart_loader;

  localparam int unsigned DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic cpu_hold, load_done, load_err;

  int tests = 0;
  int fails = 0;

  imem_uart_loader_if #(.ADDR_W(4)) imem ();

  imem_uart_loader #(
    .CLK_DIV       (DIV),
    .ADDR_W        (4),
    .HOLD_AT_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .imem      (imem),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Write log: address, data and cycles since the latest byte strobe.
  int          cyc = 0;
  int          bv_cyc = 0;
  bit          we_prev = 1'b0;
  int          dbl = 0;
  logic [3:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_lat[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.u_rx.byte_valid) bv_cyc = cyc;
    if (imem.im_we) begin
      log_addr.push_back(imem.im_addr);
      log_data.push_back(imem.im_wdata);
      log_lat.push_back(cyc - bv_cyc);
      if (we_prev) dbl++;
    end
    we_prev = imem.im_we;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_lat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    if (imem.im_we !== 1'b0) begin
      $display("FAIL %s im_we got %0b want 0", tag, imem.im_we); fails++;
    end
    tests++;
    if (imem.im_addr !== 4'd0) begin
      $display("FAIL %s im_addr got %0h want 0", tag, imem.im_addr); fails++;
    end
    tests++;
    if (imem.im_wdata !== 32'd0) begin
      $display("FAIL %s im_wdata got %08h want 00000000", tag, imem.im_wdata); fails++;
    end
    tests++;
    if (cpu_hold !== 1'b1) begin
      $display("FAIL %s cpu_hold got %0b want 1", tag, cpu_hold); fails++;
    end
    tests++;
    if (load_done !== 1'b0) begin
      $display("FAIL %s load_done got %0b want 0", tag, load_done); fails++;
    end
    tests++;
    if (load_err !== 1'b0) begin
      $display("FAIL %s load_err got %0b want 0", tag, load_err); fails++;
    end
    tests++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_noise_idle();
    clear_log();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    if (log_addr.size() !== 0) begin
      $display("FAIL noise_writes got %0d want 0", log_addr.size()); fails++;
    end
    tests++;
    if ({cpu_hold, load_done, load_err} !== 3'b100) begin
      $display("FAIL noise_flags got %03b want 100", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
  endtask

  task automatic test_normal_load();
    logic [7:0] img [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_log();
    for (int i = 0; i < 11; i++) begin
      send_byte(img[i], 1'b1);
      if (i == 6 && load_done !== 1'b0) begin
        $display("FAIL normal_mid_done got %0b want 0", load_done); fails++;
      end
      if (i == 6) tests++;
    end
    if (log_addr.size() !== 2) begin
      $display("FAIL normal_count got %0d want 2", log_addr.size()); fails++;
    end
    tests++;
    if (log_addr.size() >= 2) begin
      if (log_addr[0] !== 4'd0 || log_data[0] !== 32'h12345678) begin
        $display("FAIL normal_w0 got %0h/%08h want 0/12345678", log_addr[0], log_data[0]); fails++;
      end
      tests++;
      if (log_addr[1] !== 4'd1 || log_data[1] !== 32'hDEADBEEF) begin
        $display("FAIL normal_w1 got %0h/%08h want 1/deadbeef", log_addr[1], log_data[1]); fails++;
      end
      tests++;
      if (log_lat[0] !== 1 || log_lat[1] !== 1) begin
        $display("FAIL normal_latency got %0d,%0d want 1,1", log_lat[0], log_lat[1]); fails++;
      end
      tests++;
    end
    if ({cpu_hold, load_done, load_err} !== 3'b010) begin
      $display("FAIL normal_flags got %03b want 010", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
    if (imem.im_addr !== 4'd1 || imem.im_wdata !== 32'hDEADBEEF) begin
      $display("FAIL normal_hold_bus got %0h/%08h want 1/deadbeef", imem.im_addr, imem.im_wdata); fails++;
    end
    tests++;
  endtask

  task automatic test_zero_len();
    clear_log();
    send_byte(8'hA5, 1'b1);
    if ({cpu_hold, load_done} !== 2'b10) begin
      $display("FAIL zero_after_hdr got %02b want 10", {cpu_hold, load_done}); fails++;
    end
    tests++;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    if (log_addr.size() !== 0) begin
      $display("FAIL zero_writes got %0d want 0", log_addr.size()); fails++;
    end
    tests++;
    if ({cpu_hold, load_done, load_err} !== 3'b010) begin
      $display("FAIL zero_flags got %03b want 010", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
  endtask

  task automatic test_oversize();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    if (log_addr.size() !== 0) begin
      $display("FAIL oversize_writes got %0d want 0", log_addr.size()); fails++;
    end
    tests++;
    if ({cpu_hold, load_done, load_err} !== 3'b101) begin
      $display("FAIL oversize_flags got %03b want 101", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
  endtask

  task automatic test_frame_err();
    logic [7:0] img [7] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    if ({cpu_hold, load_done, load_err} !== 3'b101) begin
      $display("FAIL frame_flags got %03b want 101", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b1);
    if (log_addr.size() !== 1) begin
      $display("FAIL frame_reload_count got %0d want 1", log_addr.size()); fails++;
    end
    tests++;
    if (log_addr.size() >= 1) begin
      if (log_addr[0] !== 4'd0 || log_data[0] !== 32'h00000001) begin
        $display("FAIL frame_reload_w0 got %0h/%08h want 0/00000001", log_addr[0], log_data[0]); fails++;
      end
      tests++;
    end
    if ({cpu_hold, load_done, load_err} !== 3'b010) begin
      $display("FAIL frame_reload_flags got %03b want 010", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] img [7] = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("midload_reset");
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b1);
    if (log_addr.size() !== 1) begin
      $display("FAIL restart_count got %0d want 1", log_addr.size()); fails++;
    end
    tests++;
    if (log_addr.size() >= 1) begin
      if (log_addr[0] !== 4'd0 || log_data[0] !== 32'h11223344) begin
        $display("FAIL restart_w0 got %0h/%08h want 0/11223344", log_addr[0], log_data[0]); fails++;
      end
      tests++;
    end
    if ({cpu_hold, load_done, load_err} !== 3'b010) begin
      $display("FAIL restart_flags got %03b want 010", {cpu_hold, load_done, load_err}); fails++;
    end
    tests++;
  endtask

  task automatic test_pulse_width();
    if (dbl !== 0) begin
      $display("FAIL we_pulse_width got %0d multi-cycle pulses want 0", dbl); fails++;
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_noise_idle();
    test_normal_load();
    test_zero_len();
    test_oversize();
    test_frame_err();
    test_reset_mid_load();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
